mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, burst base address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, beat width.
REQ-003 SHALL have parameter READ_BURST_LEN, default 8, beats per read burst (>=1).
REQ-004 SHALL have parameter WRITE_BURST_LEN, default 8, beats per write burst (>=1).
REQ-005 SHALL have one clock and an asynchronous active-low reset: sys_clk  in  1  rising-edge clock; sys_rst_n  in  1  async active-low reset.
REQ-006 SHALL have instruction-side ports: i_req in 1 read request; i_addr in ADDR_WIDTH base address; i_gnt out 1 grant pulse; i_rdata out DATA_WIDTH read beat; i_rvalid out 1 beat valid; i_done out 1 burst-complete pulse.
REQ-007 SHALL have data-side ports: d_req in 1 request; d_we in 1 1=write burst; d_addr in ADDR_WIDTH base address; d_wdata in DATA_WIDTH write beat; d_wvalid in 1 write beat valid; d_wready out 1 write beat accepted; d_gnt out 1 grant pulse; d_rdata out DATA_WIDTH; d_rvalid out 1; d_done out 1.
REQ-008 SHALL have memory-side ports: m_req out 1 command valid; m_we out 1; m_addr out ADDR_WIDTH; m_cmd_ready in 1; m_wdata out DATA_WIDTH; m_wvalid out 1; m_wready in 1; m_rdata in DATA_WIDTH; m_rvalid in 1.

Function
REQ-009 SHALL implement states IDLE, CMD, RDATA, WDATA, DONE with a registered owner (I or D) and registered last_owner.
REQ-010 In IDLE with exactly one of i_req/d_req high, SHALL select that requester; with both high, SHALL select the one not equal to last_owner (round-robin).
REQ-011 On selection SHALL move to CMD next edge, latch owner, register m_addr from the owner's addr, register m_we = d_we for D and 0 for I, and pulse the owner's gnt for exactly the first CMD cycle.
REQ-012 In CMD SHALL hold m_req=1 with stable m_addr/m_we until m_cmd_ready=1; on that edge go to WDATA if m_we else RDATA.
REQ-013 In RDATA SHALL count beats on m_rvalid=1, drive owner's rvalid = m_rvalid, the other requester's rvalid = 0; i_rdata and d_rdata = m_rdata always.
REQ-014 In WDATA (owner D only) SHALL drive m_wvalid = d_wvalid, m_wdata = d_wdata, d_wready = m_wready, counting beats on m_wvalid&m_wready.
REQ-015 Beat counter SHALL be width clog2(max(READ_BURST_LEN,WRITE_BURST_LEN))+1, cleared on entering CMD; on the final beat (count = LEN-1 with beat handshake) SHALL go to DONE.
REQ-016 In DONE SHALL pulse owner's done for one cycle, set last_owner = owner, return to IDLE; next grant no earlier than the cycle after DONE.
REQ-017 m_rvalid outside RDATA and m_wready outside WDATA SHALL be ignored (no count, no rvalid/wready to requesters).
REQ-018 Request dropped in IDLE before selection SHALL not be granted; requester inputs after grant SHALL be don't-care except d_wdata/d_wvalid during WDATA.
REQ-019 m_wvalid, d_wready SHALL be 0 outside WDATA; m_req 0 outside CMD; gnt/done pulses never both high for I and D in the same cycle.
REQ-020 Req-to-m_req latency SHALL be 1 cycle from IDLE; a single-beat burst (LEN=1) SHALL complete with one handshake.

Reset
REQ-021 sys_rst_n=0 SHALL asynchronously force IDLE, counter 0, owner I, last_owner I (D wins first tie), and all outputs 0 (m_addr, m_wdata, rdata outputs included, m_wdata/rdata being pass-through of inputs only when selected by state).
REQ-022 Reset asserted mid-burst SHALL abort the burst with no done pulse; after release the arbiter SHALL restart from IDLE.

Verification
REQ-023 I-only read: i_req=1, i_addr=0x40, m_cmd_ready=1, 8 m_rvalid beats 0..7 -> i_gnt pulse cycle 1, m_addr=0x40 m_we=0, i_rvalid x8 with data 0..7, i_done one pulse, d_* quiet.
REQ-024 Simultaneous i_req/d_req after reset -> D granted first, then I; repeat both held -> grants alternate D,I,D,I.
REQ-025 D write, d_addr=0x80, m_wready toggling 1/0 -> exactly 8 m_wvalid&m_wready handshakes, m_wdata matches d_wdata per beat, d_done after 8th accepted beat.
REQ-026 m_cmd_ready held 0 for 5 cycles -> m_req, m_addr stable all 5 cycles, no data-state entry.
REQ-027 Stray m_rvalid in IDLE and during CMD -> no rvalid to requesters, counter unchanged.
REQ-028 Reset at beat 3 of read -> all outputs 0 immediately, no done; post-reset i_req -> fresh grant and full 8-beat burst.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction/data) burst arbiter in front of a single memory port.
// Round-robin on ties; one burst in flight at a time.
module mem_bus_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int READ_BURST_LEN  = 8,
   parameter int WRITE_BURST_LEN = 8
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic [DATA_WIDTH-1:0] i_rdata,
   output logic                  i_rvalid,
   output logic                  i_done,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   input  logic                  d_wvalid,
   output logic                  d_wready,
   output logic                  d_gnt,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  d_rvalid,
   output logic                  d_done,
   output logic                  m_req,
   output logic                  m_we,
   output logic [ADDR_WIDTH-1:0] m_addr,
   input  logic                  m_cmd_ready,
   output logic [DATA_WIDTH-1:0] m_wdata,
   output logic                  m_wvalid,
   input  logic                  m_wready,
   input  logic [DATA_WIDTH-1:0] m_rdata,
   input  logic                  m_rvalid
);

   localparam int MAX_LEN = (READ_BURST_LEN > WRITE_BURST_LEN) ?
                            READ_BURST_LEN : WRITE_BURST_LEN;
   localparam int CW = $clog2(MAX_LEN) + 1;
   localparam logic [CW-1:0] R_LAST = CW'(READ_BURST_LEN - 1);
   localparam logic [CW-1:0] W_LAST = CW'(WRITE_BURST_LEN - 1);

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_RDATA,
      S_WDATA,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_owner;
   logic                  r_last_owner;
   logic                  r_first;
   logic                  r_we;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;

   logic w_idle;
   logic w_sel_i;
   logic w_sel_d;
   logic w_rbeat;
   logic w_wbeat;
   logic w_in_rd;
   logic w_in_wr;

   assign w_idle  = (r_state == S_IDLE);
   assign w_in_rd = (r_state == S_RDATA);
   assign w_in_wr = (r_state == S_WDATA);

   // On a tie the side that did not own the previous burst wins.
   assign w_sel_d = w_idle & d_req & (~i_req | (r_last_owner == OWN_I));
   assign w_sel_i = w_idle & i_req & ~w_sel_d;

   assign w_rbeat = w_in_rd & m_rvalid;
   assign w_wbeat = w_in_wr & d_wvalid & m_wready;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_sel_i | w_sel_d)
               w_state_nxt = S_CMD;
         end
         S_CMD: begin
            if (m_cmd_ready)
               w_state_nxt = r_we ? S_WDATA : S_RDATA;
         end
         S_RDATA: begin
            if (w_rbeat && (r_cnt == R_LAST))
               w_state_nxt = S_DONE;
         end
         S_WDATA: begin
            if (w_wbeat && (r_cnt == W_LAST))
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state      <= S_IDLE;
         r_owner      <= OWN_I;
         r_last_owner <= OWN_I;
         r_first      <= 1'b0;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_addr       <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_first <= 1'b0;
         if (w_sel_i | w_sel_d) begin
            r_owner <= w_sel_d;
            r_addr  <= w_sel_d ? d_addr : i_addr;
            r_we    <= w_sel_d & d_we;
            r_cnt   <= '0;
            r_first <= 1'b1;
         end else if (w_rbeat | w_wbeat) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == S_DONE)
            r_last_owner <= r_owner;
      end
   end

   assign m_req    = (r_state == S_CMD);
   assign m_we     = r_we;
   assign m_addr   = r_addr;
   assign m_wvalid = w_in_wr & d_wvalid;
   assign m_wdata  = w_in_wr ? d_wdata : '0;
   assign d_wready = w_in_wr & m_wready;

   assign i_gnt = r_first & (r_owner == OWN_I);
   assign d_gnt = r_first & (r_owner == OWN_D);

   assign i_rdata  = w_in_rd ? m_rdata : '0;
   assign d_rdata  = w_in_rd ? m_rdata : '0;
   assign i_rvalid = w_rbeat & (r_owner == OWN_I);
   assign d_rvalid = w_rbeat & (r_owner == OWN_D);

   assign i_done = (r_state == S_DONE) & (r_owner == OWN_I);
   assign d_done = (r_state == S_DONE) & (r_owner == OWN_D);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: expectations queued at stimulus,
// popped by a negedge monitor whenever the DUT presents an event.
module tb_mem_bus_arbiter;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        i_req = 0;
   logic [31:0] i_addr = '0;
   logic        i_gnt;
   logic [31:0] i_rdata;
   logic        i_rvalid;
   logic        i_done;
   logic        d_req = 0;
   logic        d_we = 0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_wvalid = 0;
   logic        d_wready;
   logic        d_gnt;
   logic [31:0] d_rdata;
   logic        d_rvalid;
   logic        d_done;
   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic        m_cmd_ready = 0;
   logic [31:0] m_wdata;
   logic        m_wvalid;
   logic        m_wready = 0;
   logic [31:0] m_rdata = '0;
   logic        m_rvalid = 0;

   always #5 sys_clk = ~sys_clk;

   mem_bus_arbiter #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .READ_BURST_LEN(8), .WRITE_BURST_LEN(8)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
      .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_wvalid(d_wvalid), .d_wready(d_wready),
      .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
      .d_done(d_done),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
      .m_cmd_ready(m_cmd_ready), .m_wdata(m_wdata),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid)
   );

   typedef struct packed {
      logic        own;
      logic [31:0] addr;
      logic        we;
   } gnt_t;

   typedef struct packed {
      logic        own;
      logic [31:0] data;
   } rd_t;

   gnt_t        gq[$];
   rd_t         rq[$];
   logic [31:0] wq[$];
   logic        dq[$];

   int n_tests = 0;
   int n_fail  = 0;
   int n_hs    = 0;

   gnt_t        mon_g;
   rd_t         mon_r;
   logic [31:0] mon_w;
   logic        mon_d;

   function automatic void chk(string name, logic [63:0] act,
                               logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (i_gnt || d_gnt) begin
            chk("gnt_excl", 64'(i_gnt & d_gnt), 0);
            if (gq.size() == 0) begin
               chk("unexp_gnt", {62'd0, i_gnt, d_gnt}, 0);
            end else begin
               mon_g = gq.pop_front();
               chk("gnt_owner", 64'(d_gnt), 64'(mon_g.own));
               chk("gnt_addr", 64'(m_addr), 64'(mon_g.addr));
               chk("gnt_we", 64'(m_we), 64'(mon_g.we));
               chk("gnt_mreq", 64'(m_req), 1);
            end
         end
         if (i_rvalid || d_rvalid) begin
            chk("rv_excl", 64'(i_rvalid & d_rvalid), 0);
            if (rq.size() == 0) begin
               chk("unexp_rvalid", {62'd0, i_rvalid, d_rvalid}, 0);
            end else begin
               mon_r = rq.pop_front();
               chk("rv_owner", 64'(d_rvalid), 64'(mon_r.own));
               chk("rdata", 64'(d_rvalid ? d_rdata : i_rdata),
                   64'(mon_r.data));
            end
         end
         if (m_wvalid && m_wready) begin
            n_hs++;
            chk("wready_pass", 64'(d_wready), 1);
            if (wq.size() == 0) begin
               chk("unexp_wbeat", 1, 0);
            end else begin
               mon_w = wq.pop_front();
               chk("wdata", 64'(m_wdata), 64'(mon_w));
            end
         end
         if (i_done || d_done) begin
            chk("done_excl", 64'(i_done & d_done), 0);
            if (dq.size() == 0) begin
               chk("unexp_done", {62'd0, i_done, d_done}, 0);
            end else begin
               mon_d = dq.pop_front();
               chk("done_owner", 64'(d_done), 64'(mon_d));
            end
         end
      end
   end

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_cmd();
      for (int c = 0; c < 20; c++) begin
         @(negedge sys_clk);
         if (m_req) return;
      end
      chk("cmd_timeout", 0, 1);
   endtask

   // Called at a negedge with m_req high and m_cmd_ready high.
   task automatic read_burst(logic own, logic [31:0] base);
      for (int k = 0; k < 8; k++)
         rq.push_back('{own: own, data: base + 32'(k)});
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < 8; k++) begin
         m_rvalid = 1'b1;
         m_rdata  = base + 32'(k);
         step();
      end
      m_rvalid = 1'b0;
      m_rdata  = '0;
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, "_ctl"},
          {54'd0, m_req, m_we, m_wvalid, i_gnt, d_gnt,
           i_rvalid, d_rvalid, i_done, d_done, d_wready}, 0);
      chk({tag, "_maddr"}, 64'(m_addr), 0);
      chk({tag, "_mwdata"}, 64'(m_wdata), 0);
      chk({tag, "_rdata"}, {i_rdata, d_rdata}, 0);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      gq.delete(); rq.delete(); wq.delete(); dq.delete();
      repeat (2) step();
      sys_rst_n = 1'b1;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state with busy memory-side inputs.
      m_rdata  = 32'hFFFF_FFFF;
      m_rvalid = 1'b1;
      m_wready = 1'b1;
      d_wdata  = 32'h1234_5678;
      d_wvalid = 1'b1;
      #3;
      chk_all_zero("reset");
      m_rdata = '0; m_rvalid = 0; m_wready = 0;
      d_wdata = '0; d_wvalid = 0;
      do_reset();

      // I-only 8-beat read.
      gq.push_back('{own: 1'b0, addr: 32'h40, we: 1'b0});
      dq.push_back(1'b0);
      i_req = 1; i_addr = 32'h40; m_cmd_ready = 1;
      step();
      chk("lat_mreq", 64'(m_req), 1);
      chk("lat_ignt", 64'(i_gnt), 1);
      i_req = 0;
      wait_cmd();
      read_burst(1'b0, 32'h0);
      step();
      step();
      chk("post_rd_mreq", 64'(m_req), 0);

      // Tie after reset: D first, then alternation.
      do_reset();
      i_req = 1; i_addr = 32'h100;
      d_req = 1; d_addr = 32'h200; d_we = 0;
      for (int b = 0; b < 4; b++) begin
         gq.push_back('{own: (b % 2 == 0), addr: (b % 2 == 0) ?
                        32'h200 : 32'h100, we: 1'b0});
         dq.push_back(b % 2 == 0);
      end
      for (int b = 0; b < 4; b++) begin
         wait_cmd();
         read_burst(b % 2 == 0, 32'h1000 * (b + 1));
      end
      i_req = 0; d_req = 0;
      step(); step();

      // D write with toggling m_wready.
      gq.push_back('{own: 1'b1, addr: 32'h80, we: 1'b1});
      dq.push_back(1'b1);
      for (int k = 0; k < 8; k++)
         wq.push_back(32'hA000 + 32'(k * 17));
      n_hs = 0;
      d_req = 1; d_we = 1; d_addr = 32'h80;
      step();
      d_req = 0; d_we = 0; d_addr = '0;
      wait_cmd();
      @(posedge sys_clk);
      #1;
      begin
         int k;
         k = 0;
         for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
            d_wvalid = 1;
            d_wdata  = 32'hA000 + 32'(k * 17);
            m_wready = (cyc % 2 == 0);
            @(posedge sys_clk);
            if (m_wready) k++;
            #1;
         end
         d_wvalid = 0; m_wready = 0;
         chk("wr_beats", 64'(k), 8);
      end
      step(); step();
      chk("wr_hs", 64'(n_hs), 8);

      // Stray m_rvalid in IDLE, then in a stalled CMD.
      m_rvalid = 1; m_rdata = 32'hDEAD;
      for (int c = 0; c < 3; c++) begin
         @(negedge sys_clk);
         chk("idle_stray_rv", {62'd0, i_rvalid, d_rvalid}, 0);
      end
      gq.push_back('{own: 1'b0, addr: 32'h300, we: 1'b0});
      dq.push_back(1'b0);
      m_cmd_ready = 0;
      step();
      i_req = 1; i_addr = 32'h300;
      step();
      i_req = 0; i_addr = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge sys_clk);
         chk("stall_mreq", 64'(m_req), 1);
         chk("stall_addr", 64'(m_addr), 64'h300);
         chk("stall_we", 64'(m_we), 0);
         chk("stall_rv", {62'd0, i_rvalid, d_rvalid}, 0);
      end
      m_rvalid = 0; m_rdata = '0; m_cmd_ready = 1;
      read_burst(1'b0, 32'h500);
      step(); step();

      // Reset at beat 3 of a read, then a fresh full burst.
      gq.push_back('{own: 1'b0, addr: 32'h600, we: 1'b0});
      for (int k = 0; k < 3; k++)
         rq.push_back('{own: 1'b0, data: 32'h700 + 32'(k)});
      i_req = 1; i_addr = 32'h600;
      step();
      i_req = 0;
      wait_cmd();
      @(posedge sys_clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         m_rvalid = 1; m_rdata = 32'h700 + 32'(k);
         step();
      end
      m_rvalid = 1; m_rdata = 32'h703;
      d_wdata = 32'hBEEF; m_wready = 1;
      #1;
      chk("pre_rst_rv", 64'(i_rvalid), 1);
      sys_rst_n = 0;
      #1;
      chk_all_zero("midrst");
      chk("midrst_rq", 64'(rq.size()), 0);
      repeat (2) step();
      m_rvalid = 0; m_rdata = '0; d_wdata = '0; m_wready = 0;
      sys_rst_n = 1;
      repeat (3) step();
      gq.push_back('{own: 1'b0, addr: 32'h600, we: 1'b0});
      dq.push_back(1'b0);
      i_req = 1;
      step();
      chk("rst_lat_ignt", 64'(i_gnt), 1);
      i_req = 0;
      wait_cmd();
      read_burst(1'b0, 32'h800);
      step(); step();

      chk("gq_empty", 64'(gq.size()), 0);
      chk("rq_empty", 64'(rq.size()), 0);
      chk("wq_empty", 64'(wq.size()), 0);
      chk("dq_empty", 64'(dq.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
